// File: rtl/recip_nr_seq_if.sv
// Operand/result handshake bundle for recip_nr_seq.
// master drives operands and consumes results; slave is the reciprocal unit.
interface recip_nr_seq_if #(
    parameter int NSIG = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [NSIG:0] a;
    logic          out_valid;
    logic          out_ready;
    logic [NSIG:0] r;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, r
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, r
    );
endinterface

// File: rtl/recip_nr_seq.sv
// Sequential Newton-Raphson reciprocal of a 1.xxx mantissa using one shared multiplier.
// Define RECIP_NR_SEQ_EARLY_EXIT_EN to stop as soon as an iteration leaves x unchanged.
module recip_nr_seq #(
    parameter int NSIG  = 7,
    parameter int NITER = 3
) (
    input  logic          clk,
    input  logic          rst,
    recip_nr_seq_if.slave bus,
    input  logic          flush,
    output logic          busy,
    output logic [2:0]    iter
);
    localparam int W  = NSIG + 1;
    localparam int WW = 2 * NSIG + 2;

    localparam logic [W-1:0]  ONE    = W'(1) << NSIG;
    localparam logic [W-1:0]  X_INIT = ONE - W'(1);
    localparam logic [WW-1:0] TWO    = WW'(2) << NSIG;
    localparam logic [2:0]    LAST   = 3'(NITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL_AX,
        MUL_XD,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_q;
    logic [W-1:0]   x;
    logic [W-1:0]   r_q;
    logic [WW-1:0]  t;
    logic [2:0]     iter_q;

    logic [W-1:0]   d;
    logic [W-1:0]   mul_b;
    logic [WW-1:0]  prod;
    logic [W-1:0]   x_next;
    logic           accept;
    logic           is_one;
    logic           early;
    logic           finish;

    // t never drops below 2^NSIG-1, so d = 2 - t/2 always fits in W bits.
    assign d      = W'(TWO - (t >> 1));
    assign mul_b  = (state == MUL_XD) ? d : a_q;
    assign prod   = WW'(x) * WW'(mul_b);
    assign x_next = prod[NSIG +: W];

    assign accept = bus.in_valid && (state == IDLE);
    assign is_one = (bus.a == ONE);

`ifdef RECIP_NR_SEQ_EARLY_EXIT_EN
    // Same x twice means the fixed point is reached; further steps cannot move it.
    assign early  = (iter_q != 3'd0) && (x_next == x);
`else
    assign early  = 1'b0;
`endif
    assign finish = (iter_q == LAST) || early;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.r         = r_q;
    assign busy          = (state != IDLE);
    assign iter          = iter_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = is_one ? DONE : MUL_AX;
            MUL_AX:  state_nxt = MUL_XD;
            MUL_XD:  state_nxt = finish ? DONE : MUL_AX;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Flush freezes the datapath so an abandoned run leaves r untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            x      <= '0;
            t      <= '0;
            r_q    <= '0;
            iter_q <= '0;
        end else if (!flush) begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= bus.a;
                        iter_q <= '0;
                        if (is_one) r_q <= ONE;
                        else        x   <= X_INIT;
                    end
                end
                MUL_AX: t <= prod >> NSIG;
                MUL_XD: begin
                    x <= x_next;
                    if (finish) r_q    <= x_next;
                    else        iter_q <= iter_q + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_recip_nr_seq.sv
// Directed and sweep bench for recip_nr_seq; latency is counted in clock edges
// after the accept edge until out_valid is seen (0 for a == 1.0, 2*NITER otherwise).
module tb_recip_nr_seq;
    localparam int NSIG  = 7;
    localparam int NITER = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       busy;
    logic [2:0] iter;
    int         total = 0;
    int         bad   = 0;

    recip_nr_seq_if #(.NSIG(NSIG)) bus ();

    recip_nr_seq #(.NSIG(NSIG), .NITER(NITER)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .flush (flush),
        .busy  (busy),
        .iter  (iter)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent integer model of the iteration; nit is the number of iterations run.
    function automatic void model(input int av, output int rv, output int nit);
        int x, t, d, xn;
        nit = 0;
        if (av == 128) begin
            rv = 128;
            return;
        end
        x = 127;
        for (int i = 0; i < NITER; i++) begin
            t   = (av * x) >> 7;
            d   = 256 - (t >> 1);
            xn  = ((x * d) >> 7) & 255;
            nit = i + 1;
`ifdef RECIP_NR_SEQ_EARLY_EXIT_EN
            if (i >= 1 && xn == x) break;
`endif
            x = xn;
        end
        rv = x;
    endfunction

    task automatic send(input logic [NSIG:0] v, output int lat, output logic ok);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b1;
        bus.a        = v;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        ok = bus.out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (iter !== 3'd0) begin bad++; $display("FAIL reset_iter got=%0d exp=0", iter); end
        total++; if (bus.r !== 8'd0) begin bad++; $display("FAIL reset_r got=%0d exp=0", bus.r); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int lat; logic ok;
        send(8'd192, lat, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL a192_timeout got=%b exp=1", ok); end
        total++; if (lat != 6) begin bad++; $display("FAIL a192_latency got=%0d exp=6", lat); end
        total++; if (bus.r !== 8'd171) begin bad++; $display("FAIL a192_r got=%0d exp=171", bus.r); end
        total++; if (iter !== 3'd2) begin bad++; $display("FAIL a192_iter got=%0d exp=2", iter); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL a192_release got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL a192_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_one();
        int lat; logic ok;
        send(8'd128, lat, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL a128_timeout got=%b exp=1", ok); end
        total++; if (lat != 0) begin bad++; $display("FAIL a128_latency got=%0d exp=0", lat); end
        total++; if (bus.r !== 8'd128) begin bad++; $display("FAIL a128_r got=%0d exp=128", bus.r); end
        tick();
    endtask

    task automatic test_hold();
        int lat; logic ok;
        bus.out_ready = 1'b0;
        send(8'd255, lat, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL a255_timeout got=%b exp=1", ok); end
        total++; if (lat != 6) begin bad++; $display("FAIL a255_latency got=%0d exp=6", lat); end
        total++; if (bus.r !== 8'd129) begin bad++; $display("FAIL a255_r got=%0d exp=129", bus.r); end
        // A competing operand while busy must be ignored.
        bus.in_valid = 1'b1;
        bus.a        = 8'd192;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
            total++; if (bus.r !== 8'd129) begin bad++; $display("FAIL hold_r cyc=%0d got=%0d exp=129", i, bus.r); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL hold_in_ready_after got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_flush();
        int  lat; logic ok; int seen = 0;
        bus.in_valid = 1'b1;
        bus.a        = 8'd192;
        tick();
        bus.in_valid = 1'b0;
        flush        = 1'b1;
        tick();
        flush        = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_no_result got=%0d exp=0", seen); end
        // Flush wins over an accept in the same cycle.
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 8'd192;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_vs_accept got=%b exp=0", busy); end
        send(8'd128, lat, ok);
        total++; if (ok !== 1'b1 || bus.r !== 8'd128) begin bad++; $display("FAIL flush_then_128 got=%0d exp=128", bus.r); end
        tick();
        // Flush in the final MUL_XD wins over completion and leaves r alone.
        bus.in_valid = 1'b1;
        bus.a        = 8'd192;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_vs_done got=%b/%b exp=0/0", bus.out_valid, busy); end
        total++; if (bus.r !== 8'd128) begin bad++; $display("FAIL flush_vs_done_r got=%0d exp=128", bus.r); end
    endtask

    task automatic test_rst_midway();
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = 8'd192;
            tick();
            bus.in_valid = 1'b0;
            tick();
            rst   = 1'b1;
            flush = (k == 1);
            tick();
            rst   = 1'b0;
            flush = 1'b0;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid%0d_out_valid got=%b exp=0", k, bus.out_valid); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid%0d_busy got=%b exp=0", k, busy); end
            total++; if (iter !== 3'd0) begin bad++; $display("FAIL rst_mid%0d_iter got=%0d exp=0", k, iter); end
            total++; if (bus.r !== 8'd0) begin bad++; $display("FAIL rst_mid%0d_r got=%0d exp=0", k, bus.r); end
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid%0d_in_ready got=%b exp=1", k, bus.in_ready); end
        end
    endtask

    task automatic test_sweep();
        int order[128];
        int lat, exp_r, nit, exp_lat, tmp, j;
        logic ok;
        for (int i = 0; i < 128; i++) order[i] = 128 + i;
        for (int i = 127; i > 0; i--) begin
            j        = $urandom_range(i, 0);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 128; i++) begin
            model(order[i], exp_r, nit);
            exp_lat = 2 * nit;
            send(8'(order[i]), lat, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL sweep_timeout a=%0d got=%b exp=1", order[i], ok); end
            total++; if (bus.r !== 8'(exp_r)) begin bad++; $display("FAIL sweep_r a=%0d got=%0d exp=%0d", order[i], bus.r, exp_r); end
            total++; if (lat != exp_lat) begin bad++; $display("FAIL sweep_latency a=%0d got=%0d exp=%0d", order[i], lat, exp_lat); end
        end
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_one();
        test_hold();
        test_flush();
        test_rst_midway();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
